// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/gnt fetches, buffers responses for decode.
// Optional build macro FETCH_PERF_CNT_EN adds the IF_bubble_cnt_o performance counter.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IF_redirect_i,
  input  logic [DATA_WIDTH-1:0] IF_redirect_pc_i,
  input  logic                  IF_stall_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  ID_valid_o,
  output logic [DATA_WIDTH-1:0] ID_instruction_o,
  output logic [DATA_WIDTH-1:0] ID_pc_o,
  output logic [DATA_WIDTH-1:0] ID_pc_plus4_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           IF_bubble_cnt_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_instr_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc_d    [FIFO_DEPTH];

  logic              valid_s, pop_s, push_s, req_s, grant_s;
  logic [CNT_W:0]    occupancy_s;
  logic [1:0]        unused_redirect_lsb_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) ptr_inc = '0;
    else                             ptr_inc = p + PTR_W'(1);
  endfunction

  assign unused_redirect_lsb_s = IF_redirect_pc_i[1:0];

  // A redirect voids the pop and drops any response arriving in the same cycle.
  assign valid_s     = (count_q != '0);
  assign pop_s       = valid_s && !IF_stall_i && !IF_redirect_i;
  assign push_s      = imem_rvalid_i && inflight_q && !IF_redirect_i;
  assign occupancy_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop_s};
  assign req_s       = !rst && !IF_redirect_i && (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH));
  assign grant_s     = req_s && imem_gnt_i;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = grant_s;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_pc_d     = fifo_pc_q;
    if (IF_redirect_i) begin
      pc_d    = {IF_redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (grant_s) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      if (push_s) begin
        fifo_instr_d[tail_q] = imem_rdata_i;
        fifo_pc_d[tail_q]    = inflight_pc_q;
        tail_d               = ptr_inc(tail_q);
      end
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_pc_q     <= fifo_pc_d;
    end
  end

  assign imem_req_o       = req_s;
  assign imem_addr_o      = pc_q;
  assign ID_valid_o       = valid_s;
  assign ID_instruction_o = valid_s ? fifo_instr_q[head_q] : NOP_INSTR;
  assign ID_pc_o          = valid_s ? fifo_pc_q[head_q] : '0;
  assign ID_pc_plus4_o    = ID_pc_o + 32'd4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating count of cycles out of reset with no instruction presented to decode.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!valid_s && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= 32'd0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign IF_bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
